// File: rtl/flappy_pkg.sv
// flappy_pkg: shared widths, state encoding, game register bundle
// and default tuning constants for the flappy game controller.
package flappy_pkg;

  localparam int Y_W     = 9;
  localparam int VEL_W   = 8;
  localparam int SCORE_W = 8;
  localparam int CNT_W   = 8;
  localparam int SUM_W   = Y_W + 2;

  localparam int DEF_BIRD_H       = 20;
  localparam int DEF_START_Y      = 230;
  localparam int DEF_FLOOR_Y      = 480 - DEF_BIRD_H;
  localparam int DEF_GRAVITY      = 1;
  localparam int DEF_FLAP_VEL     = 8;
  localparam int DEF_MAX_FALL     = 10;
  localparam int DEF_DEAD_FRAMES  = 60;
  localparam int DEF_SCORE_FRAMES = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  typedef struct packed {
    state_t                    st;
    logic [Y_W-1:0]            y;
    logic signed [VEL_W-1:0]   vel;
    logic [SCORE_W-1:0]        score;
    logic [CNT_W-1:0]          fcnt;
    logic [CNT_W-1:0]          dcnt;
  } game_t;

  function automatic logic [SCORE_W-1:0] sat_inc(
    input logic [SCORE_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/flappy_game_ctrl_flap_sync.sv
// flap_input_sync: brings the raw flap button into dclk and
// emits a single-cycle pulse on each synchronized rising edge.
module flap_input_sync (
  input  logic dclk,
  input  logic clr_n,
  input  logic i_flap,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_flap;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: per-frame bird physics, IDLE/PLAY/DEAD sequencing
// and survival score, advanced on each falling edge of vsync.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int START_Y      = DEF_START_Y,
  parameter int FLOOR_Y      = DEF_FLOOR_Y,
  parameter int GRAVITY      = DEF_GRAVITY,
  parameter int FLAP_VEL     = DEF_FLAP_VEL,
  parameter int MAX_FALL     = DEF_MAX_FALL,
  parameter int DEAD_FRAMES  = DEF_DEAD_FRAMES,
  parameter int SCORE_FRAMES = DEF_SCORE_FRAMES
) (
  input  logic               dclk,
  input  logic               clr_n,
  input  logic               flap_in,
  input  logic               vsync,
  output logic [Y_W-1:0]     bird_y,
  output logic               game_state,
  output logic [SCORE_W-1:0] score
);

  localparam logic [Y_W-1:0] L_START = Y_W'(START_Y);
  localparam logic [Y_W-1:0] L_FLOOR = Y_W'(FLOOR_Y);
  localparam logic signed [SUM_W-1:0] L_FLOOR_S = SUM_W'(FLOOR_Y);
  localparam logic signed [VEL_W-1:0] L_FLAP = VEL_W'(-FLAP_VEL);
  localparam logic signed [VEL_W-1:0] L_GRAV = VEL_W'(GRAVITY);
  localparam logic signed [VEL_W-1:0] L_MAXF = VEL_W'(MAX_FALL);
  localparam logic [CNT_W-1:0] L_DEAD = CNT_W'(DEAD_FRAMES);
  localparam logic [CNT_W-1:0] L_FC_LAST = CNT_W'(SCORE_FRAMES - 1);

  logic                    w_edge;
  logic                    w_tick;
  logic                    w_fl;
  logic                    r_vsync_d;
  logic                    r_pend;
  game_t                   r_game;
  game_t                   w_game_n;
  logic signed [VEL_W-1:0] w_vel_grav;
  logic signed [VEL_W-1:0] w_vel_n;
  logic signed [SUM_W-1:0] w_sum;

  flap_input_sync u_sync (
    .dclk   (dclk),
    .clr_n  (clr_n),
    .i_flap (flap_in),
    .o_edge (w_edge)
  );

  assign w_tick = r_vsync_d & ~vsync;
  // an edge landing in the tick cycle still counts for that tick
  assign w_fl   = r_pend | w_edge;

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      r_vsync_d <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      if (w_tick) begin
        r_pend <= 1'b0;
      end else if (w_edge) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign w_vel_grav = r_game.vel + L_GRAV;
  assign w_vel_n = w_fl ? L_FLAP :
                   (w_vel_grav > L_MAXF) ? L_MAXF : w_vel_grav;
  assign w_sum = $signed({2'b00, r_game.y}) +
                 $signed({{(SUM_W-VEL_W){w_vel_n[VEL_W-1]}}, w_vel_n});

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      r_game <= '{st:    ST_IDLE,
                  y:     L_START,
                  vel:   '0,
                  score: '0,
                  fcnt:  '0,
                  dcnt:  '0};
    end else begin
      r_game <= w_game_n;
    end
  end

  always_comb begin
    w_game_n = r_game;
    if (w_tick) begin
      unique case (r_game.st)
        ST_IDLE: begin
          w_game_n.y   = L_START;
          w_game_n.vel = '0;
          if (w_fl) begin
            w_game_n.st    = ST_PLAY;
            w_game_n.vel   = L_FLAP;
            w_game_n.score = '0;
            w_game_n.fcnt  = '0;
          end
        end
        ST_PLAY: begin
          if (w_sum < 0) begin
            w_game_n.y   = '0;
            w_game_n.vel = '0;
          end else if (w_sum >= L_FLOOR_S) begin
            w_game_n.y    = L_FLOOR;
            w_game_n.vel  = '0;
            w_game_n.st   = ST_DEAD;
            w_game_n.dcnt = L_DEAD;
          end else begin
            w_game_n.y   = w_sum[Y_W-1:0];
            w_game_n.vel = w_vel_n;
          end
          if (r_game.fcnt == L_FC_LAST) begin
            w_game_n.fcnt  = '0;
            w_game_n.score = sat_inc(r_game.score);
          end else begin
            w_game_n.fcnt = r_game.fcnt + 1'b1;
          end
        end
        ST_DEAD: begin
          if (r_game.dcnt != '0) begin
            w_game_n.dcnt = r_game.dcnt - 1'b1;
          end else if (w_fl) begin
            w_game_n.st  = ST_IDLE;
            w_game_n.y   = L_START;
            w_game_n.vel = '0;
          end
        end
        default: begin
          w_game_n.st = ST_IDLE;
        end
      endcase
    end
  end

  assign bird_y     = r_game.y;
  assign game_state = (r_game.st == ST_PLAY);
  assign score      = r_game.score;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: directed and randomized frames against a
// behavioural game model; score period shortened to 4 frames.
module tb_flappy_game_ctrl;

  localparam int SF     = 4;
  localparam int START  = 230;
  localparam int FLOOR  = 460;
  localparam int FLAP   = 8;
  localparam int GRAV   = 1;
  localparam int MAXF   = 10;
  localparam int DEADF  = 60;

  logic       dclk    = 1'b0;
  logic       clr_n   = 1'b1;
  logic       flap_in = 1'b0;
  logic       vsync   = 1'b1;
  logic [8:0] bird_y;
  logic       game_state;
  logic [7:0] score;

  int errors = 0;
  int checks = 0;

  // model: 0 idle, 1 play, 2 dead
  int m_st, m_y, m_v, m_score, m_fc, m_dc;

  flappy_game_ctrl #(.SCORE_FRAMES(SF)) dut (
    .dclk       (dclk),
    .clr_n      (clr_n),
    .flap_in    (flap_in),
    .vsync      (vsync),
    .bird_y     (bird_y),
    .game_state (game_state),
    .score      (score)
  );

  always #20 dclk = ~dclk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_y = START; m_v = 0;
    m_score = 0; m_fc = 0; m_dc = 0;
  endtask

  task automatic model_tick(input bit fl);
    int vn, s;
    case (m_st)
      0: if (fl) begin
        m_st = 1; m_v = -FLAP; m_score = 0; m_fc = 0;
      end
      1: begin
        vn = fl ? -FLAP : ((m_v + GRAV > MAXF) ? MAXF : m_v + GRAV);
        s = m_y + vn;
        if (s < 0) begin
          m_y = 0; m_v = 0;
        end else if (s >= FLOOR) begin
          m_y = FLOOR; m_v = 0; m_st = 2; m_dc = DEADF;
        end else begin
          m_y = s; m_v = vn;
        end
        m_fc++;
        if (m_fc == SF) begin
          m_fc = 0;
          if (m_score < 255) m_score++;
        end
      end
      default: begin
        if (m_dc > 0) m_dc--;
        else if (fl) begin
          m_st = 0; m_y = START; m_v = 0;
        end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    check({tag, ".y"}, 32'(bird_y), 32'(m_y));
    check({tag, ".gs"}, 32'(game_state), 32'(m_st == 1));
    check({tag, ".score"}, 32'(score), 32'(m_score));
  endtask

  task automatic pulse_flap();
    flap_in = 1'b1;
    repeat (3) @(negedge dclk);
    flap_in = 1'b0;
    repeat (4) @(negedge dclk);
  endtask

  task automatic do_tick(input bit fl, input string tag);
    vsync = 1'b0;
    @(negedge dclk);
    model_tick(fl);
    check_model(tag);
    repeat (3) @(negedge dclk);
    vsync = 1'b1;
    repeat (2) @(negedge dclk);
  endtask

  task automatic frame(input bit fl, input string tag);
    if (fl) pulse_flap();
    do_tick(fl, tag);
  endtask

  // flap edge lands exactly in the tick cycle
  task automatic edge_in_tick(input string tag);
    flap_in = 1'b1;
    @(negedge dclk);
    @(negedge dclk);
    do_tick(1'b1, tag);
    flap_in = 1'b0;
    repeat (3) @(negedge dclk);
  endtask

  initial begin
    int n;
    bit fl;
    #5 clr_n = 1'b0;
    #1;
    check("rst.y", 32'(bird_y), 32'(START));
    check("rst.gs", 32'(game_state), 32'd0);
    check("rst.score", 32'(score), 32'd0);
    repeat (3) @(negedge dclk);
    clr_n = 1'b1;
    model_reset();
    @(negedge dclk);

    frame(1'b0, "idle_noflap");

    frame(1'b1, "start1");
    check("start1.gs_c", 32'(game_state), 32'd1);
    check("start1.y_c", 32'(bird_y), 32'd230);
    frame(1'b0, "start2");
    check("start2.y_c", 32'(bird_y), 32'd223);
    frame(1'b0, "start3");
    check("start3.y_c", 32'(bird_y), 32'd217);

    pulse_flap();
    #3 clr_n = 1'b0;
    #1;
    check("midrst.y", 32'(bird_y), 32'd230);
    check("midrst.gs", 32'(game_state), 32'd0);
    check("midrst.score", 32'(score), 32'd0);
    model_reset();
    @(negedge dclk);
    clr_n = 1'b1;
    @(negedge dclk);
    frame(1'b0, "pend_lost");

    frame(1'b1, "ceil_start");
    for (int i = 0; i < 28; i++) frame(1'b1, "ceil");
    check("ceil28.y_c", 32'(bird_y), 32'd6);
    frame(1'b1, "ceil29");
    check("ceil29.y_c", 32'(bird_y), 32'd0);
    check("ceil29.gs_c", 32'(game_state), 32'd1);

    n = 0;
    while (m_st == 1 && n < 100) begin
      frame(1'b0, "fall");
      n++;
    end
    check("floor.bound", 32'(n < 100), 32'd1);
    check("floor.y_c", 32'(bird_y), 32'd460);
    check("floor.gs_c", 32'(game_state), 32'd0);

    for (int i = 0; i < DEADF; i++) frame(1'b1, "lockout");
    check("lockout.y_c", 32'(bird_y), 32'd460);
    frame(1'b1, "revive");
    check("revive.y_c", 32'(bird_y), 32'd230);
    check("revive.gs_c", 32'(game_state), 32'd0);
    frame(1'b1, "restart");
    check("restart.gs_c", 32'(game_state), 32'd1);
    check("restart.score_c", 32'(score), 32'd0);

    for (int i = 0; i < 3; i++) begin
      flap_in = 1'b1;
      repeat (2) @(negedge dclk);
      flap_in = 1'b0;
      repeat (3) @(negedge dclk);
    end
    edge_in_tick("merge");
    check("merge.y_c", 32'(bird_y), 32'd222);
    frame(1'b0, "merge_after");
    check("merge_after.y_c", 32'(bird_y), 32'd215);
    edge_in_tick("tick_edge");
    frame(1'b0, "tick_edge_after");

    pulse_flap();
    check_model("between");
    do_tick(1'b1, "between_tick");

    vsync = 1'b0;
    @(negedge dclk);
    model_tick(1'b0);
    check_model("hold1");
    repeat (30) @(negedge dclk);
    check_model("hold2");
    vsync = 1'b1;
    repeat (2) @(negedge dclk);

    for (int i = 0; i < 1040; i++) begin
      fl = (m_y > 300) || ($urandom_range(0, 7) == 0);
      frame(fl, "rand");
    end
    check("sat.score_c", 32'(score), 32'd255);
    check("sat.gs_c", 32'(game_state), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
